// File: rtl/diff_clk_mon_pkg.sv
// diff_clk_mon_pkg: shared state encoding and fault-counter constants for diff_clk_monitor.
package diff_clk_mon_pkg;
    typedef enum logic [2:0] {OFF, SETTLE, MEASURE, LOCKED, FLT} state_t;
    localparam int FCNT_W = 8;
    localparam logic [FCNT_W-1:0] FCNT_MAX = 8'd255;
endpackage

// File: rtl/diff_clk_mon_sync.sv
// diff_clk_mon_sync: 1- or 2-stage input register; the stage count is chosen by the top from DIFF_MON_SYNC_EN.
module diff_clk_mon_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_q;
    if (STAGES == 1) begin : g_one
        always_ff @(posedge clk or posedge rst)
            if (rst) r_q <= '0;
            else r_q <= i_d;
    end else begin : g_multi
        always_ff @(posedge clk or posedge rst)
            if (rst) r_q <= '0;
            else r_q <= {r_q[STAGES-2:0], i_d};
    end
    assign o_q = r_q[STAGES-1];
endmodule

// File: rtl/diff_clk_monitor.sv
// diff_clk_monitor: IBUFDS enable sequencer and windowed edge-count health monitor.
// Define DIFF_MON_SYNC_EN for 2-flop input synchronizers (hardware); default is a single register stage.
module diff_clk_monitor
    import diff_clk_mon_pkg::*;
#(
    parameter int WINDOW_CYCLES = 1024,
    parameter int MIN_EDGES = 240,
    parameter int MAX_EDGES = 272,
    parameter int SETTLE_CYCLES = 16,
    localparam int CNT_W = $clog2(WINDOW_CYCLES + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              I,
    input  logic              IB,
    input  logic              O,
    output logic              IBUFDISABLE,
    output logic              RDY,
    output logic              FAULT,
    output logic [CNT_W-1:0]  EDGES,
    output logic [FCNT_W-1:0] FAULT_CNT
);
`ifdef DIFF_MON_SYNC_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 1;
`endif
    localparam int WIN_W = $clog2(WINDOW_CYCLES);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    state_t           r_state, w_next;
    logic             w_i_s, w_ib_s, w_o_s, r_o_d;
    logic [WIN_W-1:0] r_win_cnt;
    logic [SET_W-1:0] r_set_cnt;
    logic [CNT_W-1:0] r_edge_cnt, w_edge_fin;
    logic             r_invalid, w_invalid_fin, w_meas, w_win_end, w_good, w_rise;

    diff_clk_mon_sync #(.STAGES(SYNC_STAGES)) u_sync_i  (.clk(CLK), .rst(RST), .i_d(I),  .o_q(w_i_s));
    diff_clk_mon_sync #(.STAGES(SYNC_STAGES)) u_sync_ib (.clk(CLK), .rst(RST), .i_d(IB), .o_q(w_ib_s));
    diff_clk_mon_sync #(.STAGES(SYNC_STAGES)) u_sync_o  (.clk(CLK), .rst(RST), .i_d(O),  .o_q(w_o_s));

    // The last window cycle is judged on its own edge/invalid sample too, so use the "final" values.
    assign w_meas        = (r_state == MEASURE) || (r_state == LOCKED);
    assign w_rise        = w_o_s & ~r_o_d;
    assign w_edge_fin    = (w_rise && r_edge_cnt != '1) ? r_edge_cnt + 1'b1 : r_edge_cnt;
    assign w_invalid_fin = r_invalid | (w_i_s == w_ib_s);
    assign w_win_end     = w_meas && (r_win_cnt == WIN_W'(WINDOW_CYCLES - 1));
    assign w_good        = !w_invalid_fin && (w_edge_fin >= CNT_W'(MIN_EDGES)) && (w_edge_fin <= CNT_W'(MAX_EDGES));

    always_comb begin
        w_next = r_state;
        case (r_state)
            OFF:             w_next = SETTLE;
            SETTLE:          w_next = (r_set_cnt == SET_W'(SETTLE_CYCLES)) ? MEASURE : SETTLE;
            MEASURE, LOCKED: w_next = w_win_end ? (w_good ? LOCKED : FLT) : r_state;
            FLT:             w_next = SETTLE;
            default:         w_next = OFF;
        endcase
        if (!EN) w_next = OFF;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= OFF;
            r_o_d      <= 1'b0;
            r_set_cnt  <= '0;
            r_win_cnt  <= '0;
            r_edge_cnt <= '0;
            r_invalid  <= 1'b0;
            EDGES      <= '0;
            FAULT_CNT  <= '0;
        end else begin
            r_state    <= w_next;
            r_o_d      <= w_o_s;
            r_set_cnt  <= (r_state == SETTLE) ? r_set_cnt + 1'b1 : '0;
            r_win_cnt  <= (w_meas && !w_win_end) ? r_win_cnt + 1'b1 : '0;
            r_edge_cnt <= (w_meas && !w_win_end) ? w_edge_fin : '0;
            r_invalid  <= w_meas && !w_win_end && w_invalid_fin;
            if (w_win_end) EDGES <= w_edge_fin;
            if (w_next == FLT && FAULT_CNT != FCNT_MAX) FAULT_CNT <= FAULT_CNT + 1'b1;
        end
    end

    assign IBUFDISABLE = (r_state == OFF) || (r_state == FLT);
    assign RDY         = (r_state == LOCKED);
    assign FAULT       = (r_state == FLT);
endmodule

// File: doc/diff_clk_monitor.md
# diff_clk_monitor

Controller and health monitor for one differential clock input buffer with disable control (IBUFDS with IBUFDISABLE). Sequences the buffer enable after reset and EN, then counts rising edges of the buffer output over fixed windows of the system clock and checks the raw pair for invalid (equal) levels. It asserts RDY while the input is in range and reports faults. It sits between the board-level IBUFDS and the clock-consuming logic, which gates its use of O on RDY.

## Interface
- WINDOW_CYCLES, 1024: CLK cycles per measurement window (>= 4).
- MIN_EDGES, 240: minimum O rising edges per window for a good result.
- MAX_EDGES, 272: maximum O rising edges per window for a good result.
- SETTLE_CYCLES, 16: CLK cycles after enabling the buffer before measurement starts (>= 1).
- CNT_W, $clog2(WINDOW_CYCLES+1): edge-counter width (derived, not overridden).

Ports:
- CLK  in  1  system clock; one clock domain for all state.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  request to enable and monitor the buffer.
- I  in  1  raw positive pad level, sampled for the invalid check.
- IB  in  1  raw negative pad level.
- O  in  1  buffer output being monitored.
- IBUFDISABLE  out  1  drives the buffer disable pin; 1 = disabled.
- RDY  out  1  input clock is healthy.
- FAULT  out  1  one-cycle pulse on each failed window.
- EDGES  out  CNT_W  edge count of the last completed window.
- FAULT_CNT  out  8  saturating count of failed windows.

## Operation
- States: OFF, SETTLE, MEASURE, LOCKED, FLT.
- OFF: IBUFDISABLE=1, RDY=0. Moves to SETTLE on the next edge when EN=1.
- SETTLE: IBUFDISABLE=0. Counts SETTLE_CYCLES, then moves to MEASURE with the window and edge counters cleared.
- MEASURE and LOCKED: window counter runs 0..WINDOW_CYCLES-1.
  - A rising edge is O_s=1 with the previous sample O_d=0. Each one increments the edge counter, which saturates at 2^CNT_W-1.
  - Any cycle with I_s==IB_s sets the invalid flag for the window.
- At the window's last cycle the result is good if MIN_EDGES <= count <= MAX_EDGES and the invalid flag is clear.
  - EDGES is loaded with the count.
  - Counters and the flag clear, and the next window starts back-to-back.
  - Good: MEASURE→LOCKED, or LOCKED→LOCKED.
  - Bad: either state →FLT.
- FLT: lasts one cycle. FAULT=1, FAULT_CNT increments (saturates at 255), IBUFDISABLE=1. Next state is SETTLE if EN=1, otherwise OFF.
- RDY=1 only in LOCKED, registered.
- EN=0 in any state → OFF on the next edge. This takes priority over a window-end decision in the same cycle. EDGES and FAULT_CNT hold their values.
- The edge that enters or exits LOCKED counts the first cycle of the next window. No cycles are dropped between windows.

## Timing
- Reset values: IBUFDISABLE=1, RDY=0, FAULT=0, EDGES=0, FAULT_CNT=0, state=OFF.
- RST asserted mid-operation returns all outputs to these values immediately (asynchronous). Release is synchronous to CLK.
- Sample latency: I/IB/O reach I_s/IB_s/O_s after 2 CLK cycles with the synchronizer compiled in, or 1 cycle without it. The window ignores this latency; no compensation is applied.
- EN=1 in OFF: IBUFDISABLE falls 1 cycle later. The first window starts SETTLE_CYCLES+1 cycles after EN is sampled.
- RDY rises on the edge after the first good window ends. It falls on the edge after a bad window ends, coincident with FAULT.
- Correct counting requires f(O) < f(CLK)/2. Faster inputs alias and are expected to fail the range check.

## Configuration
- DIFF_MON_SYNC_EN defined: I, IB and O each pass through a 2-flop synchronizer before use. This is the setting for hardware.
- DIFF_MON_SYNC_EN undefined: single register stage only. Used in Verilator benches where the inputs are already CLK-aligned.
- Window decision rules are identical in both cases.

## Structure
- Package diff_clk_mon_pkg holds:
  - the state enum typedef (OFF, SETTLE, MEASURE, LOCKED, FLT);
  - the FAULT_CNT width constant (8) and its saturation value (255).
- Sub-module diff_clk_mon_sync: parameterized 1- or 2-stage synchronizer, instantiated three times (I, IB, O). Stage count is selected by DIFF_MON_SYNC_EN.

## Test plan
Default parameters for all scenarios except the first: WINDOW_CYCLES=64, MIN_EDGES=14, MAX_EDGES=18, SETTLE_CYCLES=8. O has a period of 4 CLK cycles (16 edges per window), with IB=~I.
- Reset defaults: RST pulse, EN=0 → IBUFDISABLE=1, RDY=0, EDGES=0, FAULT_CNT=0, and the state stays OFF for 100 cycles.
- Bring-up: EN=1 → IBUFDISABLE=0 after 1 cycle; RDY=1 after 1+8+64+1 cycles; EDGES=16.
- Loss of clock: O held at 0 while LOCKED → at that window's end EDGES=0, FAULT pulses once, RDY=0, FAULT_CNT=1, and SETTLE is re-entered.
- Invalid pair: I=IB=1 for 1 cycle mid-window while LOCKED → FAULT pulse and RDY drops even though EDGES=16.
- Out of range: O period 2 cycles (32 edges) → FAULT on every window. After 256 failed windows, FAULT_CNT stays at 255.
- EN drop at window end, plus async reset: EN=0 on a window's last cycle → OFF, no FAULT, EDGES updated. Separately, RST mid-window in LOCKED → all outputs return to reset values without waiting for a CLK edge.
